// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - write-back arbiter for the register bank's single write port
//
// Purpose:
//   Accepts register write requests from the ALU result path and the memory
//   load path. Each path has a one-entry holding buffer. Buffered requests are
//   serialised onto the bank's registered write port, at most one per cycle.
//   A per-register pending mask exposes writes that are buffered but not yet
//   granted, so issue logic can detect read-after-write hazards.
//
// Configuration:
//   WB_ROUND_ROBIN_EN  defined   : a tie goes to the requester not granted last
//                      undefined : fixed priority, the ALU path wins every tie
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data   ALU write request handshake
//   mem_valid/mem_ready/mem_rd/mem_data   load write request handshake
//   reg_write/write_register/write_data   registered bank write port
//   pending_mask                      bit r set while a buffered write to r is ungranted

module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_rd,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDR_W-1:0]        mem_rd,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     reg_write,
    output logic [ADDR_W-1:0]        write_register,
    output logic [DATA_W-1:0]        write_data,
    output logic [(1<<ADDR_W)-1:0]   pending_mask
);

    // Holding buffers
    logic              alu_full_q, alu_full_d;
    logic [ADDR_W-1:0] alu_rd_q,   alu_rd_d;
    logic [DATA_W-1:0] alu_data_q, alu_data_d;
    logic              mem_full_q, mem_full_d;
    logic [ADDR_W-1:0] mem_rd_q,   mem_rd_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;

    // Bank write port registers
    logic              reg_write_q,      reg_write_d;
    logic [ADDR_W-1:0] write_register_q, write_register_d;
    logic [DATA_W-1:0] write_data_q,     write_data_d;

    logic tie_alu;
    logic alu_gnt, mem_gnt;
    logic alu_acc, mem_acc;

`ifdef WB_ROUND_ROBIN_EN
    // Set when the load path received the most recent grant.
    logic last_mem_q, last_mem_d;

    assign tie_alu = last_mem_q;

    always_comb begin
        last_mem_d = last_mem_q;
        if (mem_gnt) begin
            last_mem_d = 1'b1;
        end else if (alu_gnt) begin
            last_mem_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // "ALU granted last" so the load path takes the first tie.
            last_mem_q <= 1'b0;
        end else begin
            last_mem_q <= last_mem_d;
        end
    end
`else
    assign tie_alu = 1'b1;
`endif

    // Grants depend only on buffer state, never on the incoming valids.
    assign alu_gnt = alu_full_q && (!mem_full_q || tie_alu);
    assign mem_gnt = mem_full_q && (!alu_full_q || !tie_alu);

    // A buffer being drained this cycle can take a new request at the same edge.
    assign alu_ready = rst_n && (!alu_full_q || alu_gnt);
    assign mem_ready = rst_n && (!mem_full_q || mem_gnt);

    assign alu_acc = alu_valid && alu_ready;
    assign mem_acc = mem_valid && mem_ready;

    always_comb begin
        alu_full_d = alu_full_q;
        alu_rd_d   = alu_rd_q;
        alu_data_d = alu_data_q;
        if (alu_acc) begin
            // Writes to register 0 are accepted but dropped.
            alu_full_d = (alu_rd != '0);
            alu_rd_d   = alu_rd;
            alu_data_d = alu_data;
        end else if (alu_gnt) begin
            alu_full_d = 1'b0;
        end

        mem_full_d = mem_full_q;
        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;
        if (mem_acc) begin
            mem_full_d = (mem_rd != '0);
            mem_rd_d   = mem_rd;
            mem_data_d = mem_data;
        end else if (mem_gnt) begin
            mem_full_d = 1'b0;
        end

        reg_write_d      = alu_gnt || mem_gnt;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        if (alu_gnt) begin
            write_register_d = alu_rd_q;
            write_data_d     = alu_data_q;
        end else if (mem_gnt) begin
            write_register_d = mem_rd_q;
            write_data_d     = mem_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_full_q       <= 1'b0;
            alu_rd_q         <= '0;
            alu_data_q       <= '0;
            mem_full_q       <= 1'b0;
            mem_rd_q         <= '0;
            mem_data_q       <= '0;
            reg_write_q      <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
        end else begin
            alu_full_q       <= alu_full_d;
            alu_rd_q         <= alu_rd_d;
            alu_data_q       <= alu_data_d;
            mem_full_q       <= mem_full_d;
            mem_rd_q         <= mem_rd_d;
            mem_data_q       <= mem_data_d;
            reg_write_q      <= reg_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
        end
    end

    always_comb begin
        pending_mask = '0;
        if (alu_full_q) begin
            pending_mask[alu_rd_q] = 1'b1;
        end
        if (mem_full_q) begin
            pending_mask[mem_rd_q] = 1'b1;
        end
    end

    assign reg_write      = reg_write_q;
    assign write_register = write_register_q;
    assign write_data     = write_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;
`ifdef WB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          alu_valid, mem_valid;
    logic          alu_ready, mem_ready;
    logic [AW-1:0] alu_rd, mem_rd;
    logic [DW-1:0] alu_data, mem_data;
    logic          reg_write;
    logic [AW-1:0] write_register;
    logic [DW-1:0] write_data;
    logic [NR-1:0] pending_mask;

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
        .pending_mask(pending_mask)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: each producer owns a FIFO of at most one outstanding
    // write; the bank port is a single expected (strobe, index, data) triple.
    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] d;
    } req_t;
    req_t qa[$];
    req_t qm[$];
    int            last_win;   // 0: ALU served last, 1: load served last
    logic          m_we;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_d;
    logic [DW-1:0] mdl_bank [NR];
    logic [DW-1:0] dut_bank [NR];
    bit            acc_a, acc_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model with the
    // inputs the DUT will sample at the next rising edge.
    task automatic cycle();
        int win;
        bit ra, rm;
        logic [NR-1:0] pm;
        @(negedge clk);
        win = -1;
        if (qa.size() > 0 && qm.size() > 0) win = RR ? ((last_win == 0) ? 1 : 0) : 0;
        else if (qa.size() > 0) win = 0;
        else if (qm.size() > 0) win = 1;
        ra = rst_n && (qa.size() == 0 || win == 0);
        rm = rst_n && (qm.size() == 0 || win == 1);
        pm = '0;
        foreach (qa[i]) pm[qa[i].rd] = 1'b1;
        foreach (qm[i]) pm[qm[i].rd] = 1'b1;

        chk("alu_ready",      64'(alu_ready),      64'(ra));
        chk("mem_ready",      64'(mem_ready),      64'(rm));
        chk("pending_mask",   64'(pending_mask),   64'(pm));
        chk("reg_write",      64'(reg_write),      64'(m_we));
        chk("write_register", 64'(write_register), 64'(m_rd));
        chk("write_data",     64'(write_data),     64'(m_d));

        if (reg_write === 1'b1) dut_bank[write_register] = write_data;
        if (m_we) mdl_bank[m_rd] = m_d;

        acc_a = alu_valid && ra;
        acc_m = mem_valid && rm;
        if (!rst_n) begin
            qa.delete();
            qm.delete();
            m_we = 1'b0; m_rd = '0; m_d = '0;
            last_win = 0;
        end else begin
            if (win == 0) begin
                m_we = 1'b1; m_rd = qa[0].rd; m_d = qa[0].d;
                void'(qa.pop_front());
                last_win = 0;
            end else if (win == 1) begin
                m_we = 1'b1; m_rd = qm[0].rd; m_d = qm[0].d;
                void'(qm.pop_front());
                last_win = 1;
            end else begin
                m_we = 1'b0;
            end
            if (acc_a && alu_rd != '0) qa.push_back('{rd: alu_rd, d: alu_data});
            if (acc_m && mem_rd != '0) qm.push_back('{rd: mem_rd, d: mem_data});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW-1:0] ar, mr;
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        m_we = 1'b0; m_rd = '0; m_d = '0; last_win = 0;
        for (int i = 0; i < NR; i++) begin
            mdl_bank[i] = '0;
            dut_bank[i] = '0;
        end
        cycle();
        cycle();
        rst_n = 1'b1;

        // Single uncontested ALU write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        cycle();
        alu_valid = 1'b0;
        repeat (3) cycle();

        // Load to register 0 is accepted and dropped
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h1234;
        cycle();
        mem_valid = 1'b0;
        repeat (3) cycle();

        // Both producers streaming continuously
        ar = 5'd1; mr = 5'd17;
        for (int n = 0; n < 12; n++) begin
            alu_valid = 1'b1; alu_rd = ar; alu_data = $urandom;
            mem_valid = 1'b1; mem_rd = mr; mem_data = $urandom;
            cycle();
            if (acc_a) ar = ar + 5'd1;
            if (acc_m) mr = mr + 5'd1;
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        repeat (4) cycle();

        // Same destination from both producers after a fresh reset
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'hB;
        cycle();
        alu_valid = 1'b0; mem_valid = 1'b0;
        repeat (4) cycle();

        // Reset drops a buffered write before its grant
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        cycle();
        alu_valid = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        repeat (3) cycle();

        // ALU streams 8 back-to-back requests
        for (int n = 0; n < 8; n++) begin
            alu_valid = 1'b1; alu_rd = AW'(n + 20); alu_data = $urandom;
            cycle();
        end
        alu_valid = 1'b0;
        repeat (4) cycle();

        // Random traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            alu_valid = $urandom_range(0, 3) != 0;
            mem_valid = $urandom_range(0, 3) != 0;
            alu_rd    = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            mem_rd    = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            alu_data  = $urandom;
            mem_data  = $urandom;
            cycle();
        end
        rst_n = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
        repeat (4) cycle();

        for (int i = 0; i < NR; i++) begin
            chk($sformatf("bank[%0d]", i), 64'(dut_bank[i]), 64'(mdl_bank[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
